// File: rtl/shim_sts_pkg.sv
// Shared defaults and status register bit map for the SPI status return path.
package shim_sts_pkg;

  localparam int unsigned N_CH_DEF         = 8;
  localparam int unsigned LVL_W_DEF        = 16;
  localparam int unsigned SYNC_DEPTH_DEF   = 3;
  localparam int unsigned STABLE_COUNT_DEF = 2;

  // Bit positions within the AXI status register.
  localparam int unsigned STS_RUNNING_BIT  = 0;
  localparam int unsigned STS_STOPPED_BIT  = 1;
  localparam int unsigned STS_IRQ_BIT      = 2;
  localparam int unsigned STS_STICKY_LSB   = 8;
  localparam int unsigned STS_LIVE_LSB     = 16;

endpackage

// File: rtl/shim_sts_stable_sync.sv
// Multi-flop synchronizer followed by a stability filter: the output only
// takes a synchronized value after it has stayed unchanged for STABLE_COUNT
// consecutive cycles, so skewed or transient bits never reach q_o.
module shim_sts_stable_sync #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned SYNC_DEPTH   = 3,
  parameter int unsigned STABLE_COUNT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_next_o
);

  localparam int unsigned CntW = $clog2(STABLE_COUNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_COUNT);

  logic [WIDTH-1:0] sync_q [SYNC_DEPTH];
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             change;
  logic             stable;

  assign dout = sync_q[SYNC_DEPTH-1];

  // Synchronizer chain, previous-value register, counter and output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_DEPTH; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= dout;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  // Stability counter; a load is also blocked on the cycle a change is seen,
  // since the saturated count still reflects the old value then.
  always_comb begin
    change = (dout != prev_q);
    cnt_d  = cnt_q;
    if (change) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    stable = (cnt_q == CntMax) && !change;
    out_d  = stable ? dout : out_q;
  end

  assign q_o      = out_q;
  assign q_next_o = out_d;

endmodule

// File: rtl/shim_spi_sts_sync.sv
// SPI-domain status return path: filtered running flag, fault flags and
// buffer level, plus W1C sticky faults, level irq and a stopped event pulse.
module shim_spi_sts_sync
  import shim_sts_pkg::*;
#(
  parameter int unsigned N_CH         = N_CH_DEF,
  parameter int unsigned LVL_W        = LVL_W_DEF,
  parameter int unsigned SYNC_DEPTH   = SYNC_DEPTH_DEF,
  parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_running_in,
  input  logic [N_CH-1:0]  over_thresh_in,
  input  logic [LVL_W-1:0] buf_level_in,
  input  logic             sts_clear,
  input  logic [N_CH-1:0]  sts_clear_mask,
  output logic             spi_running_stable,
  output logic [N_CH-1:0]  over_thresh_stable,
  output logic [LVL_W-1:0] buf_level_stable,
  output logic [N_CH-1:0]  over_thresh_sticky,
  output logic             irq,
  output logic             stopped_pulse
);

  logic             run_next;
  logic [N_CH-1:0]  ot_next;
  logic [LVL_W-1:0] lvl_next;
  logic             unused_next;

  logic [N_CH-1:0]  sticky_q, sticky_d;
  logic             irq_q, irq_d;
  logic             pulse_q, pulse_d;

  shim_sts_stable_sync #(
    .WIDTH        (1),
    .SYNC_DEPTH   (SYNC_DEPTH),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_run_sync (
    .clk_i    (clk),
    .rst_i    (rst),
    .d_i      (spi_running_in),
    .q_o      (spi_running_stable),
    .q_next_o (run_next)
  );

  shim_sts_stable_sync #(
    .WIDTH        (N_CH),
    .SYNC_DEPTH   (SYNC_DEPTH),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_ot_sync (
    .clk_i    (clk),
    .rst_i    (rst),
    .d_i      (over_thresh_in),
    .q_o      (over_thresh_stable),
    .q_next_o (ot_next)
  );

  shim_sts_stable_sync #(
    .WIDTH        (LVL_W),
    .SYNC_DEPTH   (SYNC_DEPTH),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_lvl_sync (
    .clk_i    (clk),
    .rst_i    (rst),
    .d_i      (buf_level_in),
    .q_o      (buf_level_stable),
    .q_next_o (lvl_next)
  );

  // Only the running group needs its next value (for the falling-edge pulse).
  assign unused_next = ^{ot_next, lvl_next};

  // Sticky next-state: set wins over clear; irq and pulse are registered.
  always_comb begin
    sticky_d = (sticky_q & ~({N_CH{sts_clear}} & sts_clear_mask)) | over_thresh_stable;
    irq_d    = |sticky_q;
    pulse_d  = spi_running_stable & ~run_next;
  end

  // Sticky, irq and stopped-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      irq_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
      pulse_q  <= pulse_d;
    end
  end

  assign over_thresh_sticky = sticky_q;
  assign irq                = irq_q;
  assign stopped_pulse      = pulse_q;

endmodule

// File: tb/tb_shim_spi_sts_sync.sv
// Directed bench for shim_spi_sts_sync at default parameters.
module tb_shim_spi_sts_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_running_in;
  logic [7:0]  over_thresh_in;
  logic [15:0] buf_level_in;
  logic        sts_clear;
  logic [7:0]  sts_clear_mask;
  logic        spi_running_stable;
  logic [7:0]  over_thresh_stable;
  logic [15:0] buf_level_stable;
  logic [7:0]  over_thresh_sticky;
  logic        irq;
  logic        stopped_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] lvl_in;
    logic [15:0] exp_lvl;
  } vec_t;

  vec_t vecs[$];

  shim_spi_sts_sync dut (
    .clk                (clk),
    .rst                (rst),
    .spi_running_in     (spi_running_in),
    .over_thresh_in     (over_thresh_in),
    .buf_level_in       (buf_level_in),
    .sts_clear          (sts_clear),
    .sts_clear_mask     (sts_clear_mask),
    .spi_running_stable (spi_running_stable),
    .over_thresh_stable (over_thresh_stable),
    .buf_level_stable   (buf_level_stable),
    .over_thresh_sticky (over_thresh_sticky),
    .irq                (irq),
    .stopped_pulse      (stopped_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " lvl"}, 32'(buf_level_stable), 32'h0);
    chk({name, " run"}, 32'(spi_running_stable), 32'h0);
    chk({name, " ot"}, 32'(over_thresh_stable), 32'h0);
    chk({name, " sticky"}, 32'(over_thresh_sticky), 32'h0);
    chk({name, " irq"}, 32'(irq), 32'h0);
    chk({name, " pulse"}, 32'(stopped_pulse), 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    spi_running_in = 1'b0;
    over_thresh_in = 8'h00;
    buf_level_in   = 16'h0000;
    sts_clear      = 1'b0;
    sts_clear_mask = 8'h00;

    // Level vectors: first capture, hold, toggling, then a new hold.
    for (int j = 0; j < 7; j++) vecs.push_back('{16'h1234, (j == 6) ? 16'h1234 : 16'h0000});
    for (int j = 0; j < 2; j++) vecs.push_back('{16'h1234, 16'h1234});
    for (int j = 0; j < 12; j++)
      vecs.push_back('{(j % 2 == 0) ? 16'hFF00 : 16'h00FF, 16'h1234});
    for (int j = 0; j < 8; j++) vecs.push_back('{16'hFF00, (j < 6) ? 16'h1234 : 16'hFF00});

    repeat (3) tick();
    chk_all_zero("reset");

    // Items 1 and 2: latency, toggling suppression, coherent update.
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      buf_level_in = vecs[i].lvl_in;
      tick();
      chk($sformatf("lvl row %0d", i), 32'(buf_level_stable), 32'(vecs[i].exp_lvl));
    end
    chk("idle run", 32'(spi_running_stable), 32'h0);
    chk("idle sticky", 32'(over_thresh_sticky), 32'h0);
    chk("idle irq", 32'(irq), 32'h0);

    // Item 3a: a two-cycle fault pulse is filtered out.
    over_thresh_in = 8'h08;
    repeat (2) tick();
    over_thresh_in = 8'h00;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("short ot %0d", j), 32'(over_thresh_stable), 32'h0);
      chk($sformatf("short sticky %0d", j), 32'(over_thresh_sticky), 32'h0);
    end

    // Item 3b: a five-cycle fault passes, latches and raises irq.
    for (int j = 0; j < 16; j++) begin
      over_thresh_in = (j < 5) ? 8'h08 : 8'h00;
      tick();
      chk($sformatf("ot %0d", j), 32'(over_thresh_stable), (j >= 6 && j <= 10) ? 32'h08 : 32'h0);
      chk($sformatf("sticky %0d", j), 32'(over_thresh_sticky), (j >= 7) ? 32'h08 : 32'h0);
      chk($sformatf("irq %0d", j), 32'(irq), (j >= 8) ? 32'h1 : 32'h0);
    end

    // Item 4: clear with source low.
    sts_clear = 1'b1; sts_clear_mask = 8'h08;
    tick();
    sts_clear = 1'b0; sts_clear_mask = 8'h00;
    chk("clr sticky", 32'(over_thresh_sticky), 32'h0);
    chk("clr irq lag", 32'(irq), 32'h1);
    tick();
    chk("clr irq", 32'(irq), 32'h0);

    // Clear while the live flag is high: set wins, repeatedly.
    over_thresh_in = 8'h08;
    repeat (8) tick();
    chk("hi ot", 32'(over_thresh_stable), 32'h08);
    chk("hi sticky", 32'(over_thresh_sticky), 32'h08);
    sts_clear = 1'b1; sts_clear_mask = 8'h08;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("hi clr sticky %0d", j), 32'(over_thresh_sticky), 32'h08);
    end
    sts_clear_mask = 8'h04;
    tick();
    chk("hi mask4 sticky", 32'(over_thresh_sticky), 32'h08);
    sts_clear = 1'b0; sts_clear_mask = 8'h00;

    // Source low again: wrong-bit mask does nothing, held clear clears.
    over_thresh_in = 8'h00;
    repeat (8) tick();
    chk("lo ot", 32'(over_thresh_stable), 32'h0);
    chk("lo sticky", 32'(over_thresh_sticky), 32'h08);
    sts_clear = 1'b1; sts_clear_mask = 8'h04;
    tick();
    chk("mask4 sticky", 32'(over_thresh_sticky), 32'h08);
    sts_clear_mask = 8'h08;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("held clr sticky %0d", j), 32'(over_thresh_sticky), 32'h0);
    end
    sts_clear = 1'b0; sts_clear_mask = 8'h00;
    tick();
    chk("held clr irq", 32'(irq), 32'h0);

    // Item 5: running rise gives no pulse, fall gives one pulse.
    spi_running_in = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("rise run %0d", j), 32'(spi_running_stable), (j >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("rise pulse %0d", j), 32'(stopped_pulse), 32'h0);
    end
    spi_running_in = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("fall run %0d", j), 32'(spi_running_stable), (j < 6) ? 32'h1 : 32'h0);
      chk($sformatf("fall pulse %0d", j), 32'(stopped_pulse), (j == 6) ? 32'h1 : 32'h0);
    end

    // Item 6: async reset mid-filter, then full latency after release.
    over_thresh_in = 8'h01;
    spi_running_in = 1'b1;
    repeat (9) tick();
    chk("pre rst sticky", 32'(over_thresh_sticky), 32'h01);
    chk("pre rst irq", 32'(irq), 32'h1);
    chk("pre rst run", 32'(spi_running_stable), 32'h1);
    buf_level_in = 16'h5A5A;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 chk_all_zero("async rst");
    tick();
    tick();
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("post rst lvl %0d", j), 32'(buf_level_stable),
          (j >= 6) ? 32'h5A5A : 32'h0);
      chk($sformatf("post rst run %0d", j), 32'(spi_running_stable), (j >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("post rst pulse %0d", j), 32'(stopped_pulse), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shim_spi_sts_sync.md
Name: shim_spi_sts_sync

Overview:
- Return-path companion to the SPI-domain config synchronizer. Carries SPI-domain status (running flag, per-channel over-threshold faults, buffer level) into the AXI/system clock domain.
- Each status group is filtered for stability before it is registered.
- Per-channel faults are latched into write-1-to-clear sticky bits.
- Drives a level interrupt and a "SPI stopped" event pulse for the AXI status register block.

Parameters:
- N_CH, 8, number of DAC/ADC channels with over-threshold fault bits.
- LVL_W, 16, width of the SPI-domain buffer level word.
- SYNC_DEPTH, 3, flop stages in each synchronizer chain (min 2).
- STABLE_COUNT, 2, consecutive unchanged synchronized cycles required before an output group updates (min 1).

Ports:
- clk  in  1  AXI/system clock; only clock.
- rst  in  1  reset, asynchronous, active-high.
- spi_running_in  in  1  SPI-domain running flag (asynchronous to clk).
- over_thresh_in  in  N_CH  SPI-domain per-channel over-threshold flags (asynchronous).
- buf_level_in  in  LVL_W  SPI-domain buffer level (asynchronous, multi-bit).
- sts_clear  in  1  one-cycle pulse from AXI write; clears sticky bits selected by sts_clear_mask.
- sts_clear_mask  in  N_CH  write-1-to-clear mask, sampled only when sts_clear=1.
- spi_running_stable  out  1  filtered running flag.
- over_thresh_stable  out  N_CH  filtered live fault flags.
- buf_level_stable  out  LVL_W  filtered coherent buffer level.
- over_thresh_sticky  out  N_CH  latched fault flags.
- irq  out  1  registered OR of over_thresh_sticky.
- stopped_pulse  out  1  one-cycle pulse on spi_running_stable 1->0.

Behaviour:
- Reset (async assert, release on clk edge): all sync flops, stability counters, outputs, sticky bits, irq and stopped_pulse go to 0.
- Three independent groups: running (1b), over_thresh (N_CH), buf_level (LVL_W). Each group has its own chain and counter.
- Chain: SYNC_DEPTH flops; dout = last stage.
- Counter per group, saturating at STABLE_COUNT:
  - cleared to 0 on any cycle where dout differs from its previous-cycle value;
  - otherwise incremented.
- stable = (count == STABLE_COUNT). The output register loads dout on every cycle where stable=1.
- Latency: an input held constant from capture edge k appears on the output at edge k+SYNC_DEPTH+STABLE_COUNT+1 (6 cycles at defaults).
- Coherence: a multi-bit group never shows a value that was not held for STABLE_COUNT+1 synchronized cycles. Transient or skewed bits are suppressed. The output holds its last stable value while the input is changing.
- Pulses shorter than STABLE_COUNT+1 cycles are filtered and never reach the outputs or the sticky bits.
- Sticky bits, per bit i, each cycle: sticky[i] <= (sticky[i] & ~(sts_clear & sts_clear_mask[i])) | over_thresh_stable[i].
  - Set wins over a simultaneous clear.
  - Clearing while the live flag is still 1 leaves sticky[i]=1.
- irq = registered |over_thresh_sticky, so it lags the sticky bits by one cycle.
- stopped_pulse: registered spi_running_stable & ~spi_running_stable_next. It is high exactly one cycle, the cycle after spi_running_stable falls. No pulse for a rising edge or for reset.
- sts_clear held high for multiple cycles: the clear applies every cycle it is high; no other effect.
- Reset mid-filtering: the pending value is discarded. After release, the first visible update needs the full latency again.

Decomposition:
- Shared package shim_sts_pkg: default N_CH, LVL_W, SYNC_DEPTH, STABLE_COUNT, and the sticky/clear bit-index constants used by the AXI status register map.
- One sub-module: shim_sts_stable_sync (params WIDTH, SYNC_DEPTH, STABLE_COUNT). It contains the async active-high reset chain, the counter and the output register with load on stable. It is instantiated three times.
- Sticky, irq and edge logic stay in the top.

Test Plan (defaults):
1. Assert rst, then release; hold buf_level_in=0x1234 from edge k -> buf_level_stable=0x0000 through k+5, =0x1234 at k+6; all other outputs 0.
2. Toggle buf_level_in between 0x00FF and 0xFF00 every cycle for 12 cycles, then hold 0xFF00 -> output stays 0x1234 during toggling and becomes 0xFF00 exactly 6 cycles after the hold starts; never shows a mixed value.
3. Drive over_thresh_in=0x08 for 2 cycles -> nothing changes. Drive it for 5 cycles -> over_thresh_stable[3] pulses, over_thresh_sticky=0x08, irq=1 one cycle later.
4. With sticky=0x08 and the source low, pulse sts_clear with mask 0x08 -> sticky=0x00 next cycle, irq=0 the cycle after. Repeat with the source held high -> sticky stays 0x08. Mask 0x04 -> no change.
5. spi_running_in goes 1->0 and is held -> spi_running_stable falls after 6 cycles, stopped_pulse high for exactly 1 cycle. A 0->1 transition produces no pulse.
6. Assert rst asynchronously mid-way through item 1's filtering window -> all outputs 0 immediately. After release the new value appears only after the full 6-cycle latency.
